// File: rtl/score_to_ascii.sv
// Binary game counter to two ASCII digits via a 7-step shift-add-3 conversion.
// Values above 99 saturate; busy covers the conversion and done pulses once per result.
module score_to_ascii #(
    parameter int IN_W       = 8,
    parameter bit LEAD_BLANK = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [IN_W-1:0] value,
    output logic            busy,
    output logic            done,
    output logic [15:0]     text_out
);

    typedef enum logic [1:0] {IDLE, CONV, FORMAT} state_t;

    localparam logic [15:0] TEXT_RST = LEAD_BLANK ? 16'h2030 : 16'h3030;

    state_t      state_q, state_d;
    logic [6:0]  shreg_q, shreg_d;
    logic [7:0]  bcd_q, bcd_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] text_q, text_d;
    logic        done_q, done_d;

    logic [6:0]  sat_val;
    logic [3:0]  tens_adj, units_adj;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        text_d  = text_q;
        done_d  = 1'b0;

        sat_val   = (value > IN_W'(99)) ? 7'd99 : value[6:0];
        tens_adj  = (bcd_q[7:4] >= 4'd5) ? bcd_q[7:4] + 4'd3 : bcd_q[7:4];
        units_adj = (bcd_q[3:0] >= 4'd5) ? bcd_q[3:0] + 4'd3 : bcd_q[3:0];

        case (state_q)
            IDLE: begin
                if (start) begin
                    shreg_d = sat_val;
                    bcd_d   = 8'd0;
                    cnt_d   = 3'd0;
                    state_d = CONV;
                end
            end
            CONV: begin
                // tens never exceeds 9, so its adjusted MSB is always zero
                bcd_d   = {tens_adj[2:0], units_adj, shreg_q[6]};
                shreg_d = {shreg_q[5:0], 1'b0};
                cnt_d   = cnt_q + 3'd1;
                if (cnt_q == 3'd6) state_d = FORMAT;
            end
            FORMAT: begin
                text_d[7:0]  = {4'h3, bcd_q[3:0]};
                text_d[15:8] = (bcd_q[7:4] == 4'd0 && LEAD_BLANK) ? 8'h20 : {4'h3, bcd_q[7:4]};
                done_d       = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= 7'd0;
            bcd_q   <= 8'd0;
            cnt_q   <= 3'd0;
            text_q  <= TEXT_RST;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            text_q  <= text_d;
            done_q  <= done_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign text_out = text_q;

endmodule

// File: tb/tb_score_to_ascii.sv
// Directed bench for score_to_ascii: both LEAD_BLANK settings run side by side.
module tb_score_to_ascii;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  value;
    logic        busy_b, done_b, busy_z, done_z;
    logic [15:0] text_b, text_z;

    int n_chk  = 0;
    int n_fail = 0;

    score_to_ascii #(.IN_W(8), .LEAD_BLANK(1'b1)) u_blank (
        .clk(clk), .rst(rst), .start(start), .value(value),
        .busy(busy_b), .done(done_b), .text_out(text_b)
    );

    score_to_ascii #(.IN_W(8), .LEAD_BLANK(1'b0)) u_zero (
        .clk(clk), .rst(rst), .start(start), .value(value),
        .busy(busy_z), .done(done_z), .text_out(text_z)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [7:0]  v;
        logic [15:0] exp_b;
        logic [15:0] exp_z;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic chk_status(input string name, input logic bsy, input logic dn);
        chk({name, " busy_b"}, {15'd0, busy_b}, {15'd0, bsy});
        chk({name, " done_b"}, {15'd0, done_b}, {15'd0, dn});
        chk({name, " busy_z"}, {15'd0, busy_z}, {15'd0, bsy});
        chk({name, " done_z"}, {15'd0, done_z}, {15'd0, dn});
    endtask

    // Called just after a falling edge with the DUTs idle; returns at the
    // falling edge inside the done cycle. inj >= 0 requests a start of 88
    // sampled at edge N+inj+1, which must be ignored.
    task automatic run(input logic [7:0] v, input logic [15:0] exp_b,
                       input logic [15:0] exp_z, input int inj);
        start = 1'b1;
        value = v;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        value = 8'($urandom);
        for (int i = 0; i < 8; i++) begin
            chk_status($sformatf("conv v=%0d cyc%0d", v, i), 1'b1, 1'b0);
            if (i == inj) begin
                start = 1'b1;
                value = 8'd88;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
        end
        chk_status($sformatf("done v=%0d", v), 1'b0, 1'b1);
        chk($sformatf("text_b v=%0d", v), text_b, exp_b);
        chk($sformatf("text_z v=%0d", v), text_z, exp_z);
    endtask

    initial begin
        vecs[0] = '{8'd42,  16'h3432, 16'h3432};
        vecs[1] = '{8'd7,   16'h2037, 16'h3037};
        vecs[2] = '{8'd0,   16'h2030, 16'h3030};
        vecs[3] = '{8'd99,  16'h3939, 16'h3939};
        vecs[4] = '{8'd250, 16'h3939, 16'h3939};
        vecs[5] = '{8'd100, 16'h3939, 16'h3939};
        vecs[6] = '{8'd10,  16'h3130, 16'h3130};
        vecs[7] = '{8'd9,   16'h2039, 16'h3039};
        vecs[8] = '{8'd255, 16'h3939, 16'h3939};

        rst   = 1'b0;
        start = 1'b0;
        value = 8'd0;
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_status("reset", 1'b0, 1'b0);
        chk("reset text_b", text_b, 16'h2030);
        chk("reset text_z", text_z, 16'h3030);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk_status("idle", 1'b0, 1'b0);
        chk("idle text_b", text_b, 16'h2030);

        foreach (vecs[k]) begin
            run(vecs[k].v, vecs[k].exp_b, vecs[k].exp_z, -1);
            @(negedge clk);
            chk_status($sformatf("after v=%0d", vecs[k].v), 1'b0, 1'b0);
            chk($sformatf("hold text_b v=%0d", vecs[k].v), text_b, vecs[k].exp_b);
        end

        // start during conversion ignored, then back-to-back start in the done cycle
        run(8'd13, 16'h3133, 16'h3133, 2);
        run(8'd88, 16'h3838, 16'h3838, -1);
        @(negedge clk);
        chk_status("after b2b", 1'b0, 1'b0);

        // reset mid-conversion abandons it without a done pulse
        start = 1'b1;
        value = 8'd55;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk_status("midrst", 1'b0, 1'b0);
        chk("midrst text_b", text_b, 16'h2030);
        chk("midrst text_z", text_z, 16'h3030);
        repeat (2) begin
            @(negedge clk);
            chk_status("midrst hold", 1'b0, 1'b0);
        end
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk_status("post rst idle", 1'b0, 1'b0);
        end
        chk("post rst text_b", text_b, 16'h2030);
        run(8'd21, 16'h3231, 16'h3231, -1);
        @(negedge clk);
        chk_status("final", 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
